// File: rtl/logic_processor_n.sv
// Bit-serial two-register logic processor: A and B shift right WIDTH times per
// Execute request, with a bitwise function of the outgoing LSBs routed into the MSBs.
module logic_processor_n #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_a,
  input  logic             i_load_b,
  input  logic             i_execute,
  input  logic [WIDTH-1:0] i_din,
  input  logic [2:0]       i_f,
  input  logic [1:0]       i_r,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [2:0]       r_f, w_f_next;
  logic [1:0]       r_r, w_r_next;
  logic             r_done, w_done_next;

  logic w_bit_a, w_bit_b, w_fn, w_new_a, w_new_b, w_any_load;

  assign w_bit_a    = r_a[0];
  assign w_bit_b    = r_b[0];
  assign w_any_load = i_load_a | i_load_b;

  always_comb begin
    w_fn = 1'b0;
    case (r_f)
      3'b000: w_fn = w_bit_a & w_bit_b;
      3'b001: w_fn = w_bit_a | w_bit_b;
      3'b010: w_fn = w_bit_a ^ w_bit_b;
      3'b011: w_fn = 1'b1;
      3'b100: w_fn = ~(w_bit_a & w_bit_b);
      3'b101: w_fn = ~(w_bit_a | w_bit_b);
      3'b110: w_fn = ~(w_bit_a ^ w_bit_b);
      default: w_fn = 1'b0;
    endcase
  end

  // Routing uses the snapshot taken at Execute, never the live R input.
  always_comb begin
    w_new_a = w_bit_a;
    w_new_b = w_bit_b;
    case (r_r)
      2'b00: begin w_new_a = w_bit_a; w_new_b = w_bit_b; end
      2'b01: begin w_new_a = w_bit_a; w_new_b = w_fn;    end
      2'b10: begin w_new_a = w_fn;    w_new_b = w_bit_b; end
      default: begin w_new_a = w_bit_b; w_new_b = w_bit_a; end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_cnt_next   = r_cnt;
    w_f_next     = r_f;
    w_r_next     = r_r;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_load_a) w_a_next = i_din;
        if (i_load_b) w_b_next = i_din;
        if (!w_any_load && i_execute) begin
          w_f_next     = i_f;
          w_r_next     = i_r;
          w_cnt_next   = '0;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_a_next   = {w_new_a, r_a[WIDTH-1:1]};
        w_b_next   = {w_new_b, r_b[WIDTH-1:1]};
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_cnt_next   = r_cnt;
          w_state_next = S_HOLD;
          w_done_next  = 1'b1;
        end
      end
      S_HOLD: begin
        // Staying here while Execute is held gives one operation per assertion.
        if (i_load_a) w_a_next = i_din;
        if (i_load_b) w_b_next = i_din;
        if (!i_execute) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_cnt   <= w_cnt_next;
      r_f     <= w_f_next;
      r_r     <= w_r_next;
      r_done  <= w_done_next;
    end
  end

  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_busy = (r_state == S_SHIFT);
  assign o_done = r_done;

endmodule
